number_respawn_scheduler: RTL and testbench

//  Controls the NUMBERS on-screen digits drawn by the number display array. On a hit it hides the

---
 rtl/number_respawn_scheduler.sv | 118 +++++++++++
 tb/tb_number_respawn_scheduler.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/number_respawn_scheduler.sv
// number_respawn_scheduler: hides hit digit slots for HIDE_FRAMES frames, respawns them
// with a pseudo-random digit 0..9 and queues collected digits to the score logic.
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   startOfFrame          1-cycle pulse per video frame
//   freeze                pause: hidden timers hold, hits ignored
//   singleHit[N]          per-slot hit pulse
//   numbersToShow[N*4]    current digit per slot (slot i at bits 4i+3:4i)
//   showNum[N]            1 = slot drawn
//   scoreValid/Idx/Digit  collected-digit event, held until scoreReady
//   scoreReady            score logic accepts the event
// Optional: define NUMSCHED_HIT_COUNT_EN to add hitCount[15:0], a saturating count of accepted hits.
module number_respawn_scheduler #(
  parameter int NUMBERS = 3,
  parameter int HIDE_FRAMES = 450,
  parameter int TIMER_W = 9,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic clk,
  input  logic reset,
  input  logic startOfFrame,
  input  logic freeze,
  input  logic [NUMBERS-1:0] singleHit,
  output logic [NUMBERS*4-1:0] numbersToShow,
  output logic [NUMBERS-1:0] showNum,
  output logic scoreValid,
  output logic [1:0] scoreIdx,
  output logic [3:0] scoreDigit,
  input  logic scoreReady
`ifdef NUMSCHED_HIT_COUNT_EN
  ,
  output logic [15:0] hitCount
`endif
);
  typedef enum logic [1:0] {SHOW, HIDDEN, LOAD} state_t;
  state_t state [NUMBERS];
  state_t state_n [NUMBERS];
  logic [TIMER_W-1:0] timer [NUMBERS];
  logic [3:0] digit [NUMBERS];
  logic [3:0] pdig [NUMBERS];
  logic [NUMBERS-1:0] pend, hit, load, clr;
  logic [7:0] lfsr;
  logic [1:0] rr, gnt, j;
  logic tick, taken, accept;
  logic [3:0] new_digit;
  assign tick = startOfFrame & ~freeze;
  assign accept = scoreValid & scoreReady;
  // 10..15 fold onto 4..9 so every draw yields a decimal digit
  assign new_digit = lfsr[3:0] < 4'd10 ? lfsr[3:0] : lfsr[3:0] - 4'd6;
  assign clr = accept ? NUMBERS'(1) << scoreIdx : '0;
  always_comb begin
    taken = 1'b0;
    for (int i = 0; i < NUMBERS; i++) begin
      hit[i] = state[i] == SHOW && singleHit[i] && !freeze && !pend[i];
      // only the lowest-index LOAD slot draws from the LFSR this cycle
      load[i] = state[i] == LOAD && !taken;
      taken = taken | (state[i] == LOAD);
      state_n[i] = hit[i] ? HIDDEN :
                   (state[i] == HIDDEN && tick && timer[i] == TIMER_W'(1)) ? LOAD :
                   load[i] ? SHOW : state[i];
      showNum[i] = state[i] == SHOW;
      numbersToShow[4*i +: 4] = digit[i];
    end
  end
  // round-robin: scanning downward leaves the first set slot at or after rr in gnt
  always_comb begin
    gnt = '0;
    j = '0;
    for (int k = NUMBERS - 1; k >= 0; k--) begin
      j = 2'((int'(rr) + k) % NUMBERS);
      if (pend[j]) gnt = j;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUMBERS; i++) begin
        state[i] <= SHOW;
        timer[i] <= '0;
        digit[i] <= 4'(i % 10);
        pdig[i] <= '0;
      end
      pend <= '0;
      scoreValid <= 1'b0;
      scoreIdx <= '0;
      scoreDigit <= '0;
      rr <= '0;
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      for (int i = 0; i < NUMBERS; i++) begin
        state[i] <= state_n[i];
        if (hit[i]) begin
          timer[i] <= TIMER_W'(HIDE_FRAMES);
          pdig[i] <= digit[i];
        end else if (state[i] == HIDDEN && tick) timer[i] <= timer[i] - 1'b1;
        if (load[i]) digit[i] <= new_digit;
      end
      // hits were qualified against the old pend, so an accepted slot cannot be re-hit this cycle
      pend <= (pend & ~clr) | hit;
      if (accept) begin
        scoreValid <= 1'b0;
        rr <= int'(scoreIdx) + 1 == NUMBERS ? 2'd0 : scoreIdx + 2'd1;
      end else if (!scoreValid && |pend) begin
        scoreValid <= 1'b1;
        scoreIdx <= gnt;
        scoreDigit <= pdig[gnt];
      end
    end
  end
`ifdef NUMSCHED_HIT_COUNT_EN
  logic [16:0] hc_sum;
  assign hc_sum = {1'b0, hitCount} + 17'($countones(hit));
  always_ff @(posedge clk) begin
    if (reset) hitCount <= '0;
    else hitCount <= hc_sum[16] ? 16'hFFFF : hc_sum[15:0];
  end
`endif
endmodule

// File: tb/tb_number_respawn_scheduler.sv
// tb_number_respawn_scheduler: directed scenarios plus random traffic checked against a behavioural model.
module tb_number_respawn_scheduler;
  localparam int N = 3;
  localparam int HF = 3;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic startOfFrame = 1'b0;
  logic freeze = 1'b0;
  logic scoreReady = 1'b0;
  logic [N-1:0] singleHit = '0;
  logic [N*4-1:0] numbersToShow;
  logic [N-1:0] showNum;
  logic scoreValid;
  logic [1:0] scoreIdx;
  logic [3:0] scoreDigit;
`ifdef NUMSCHED_HIT_COUNT_EN
  logic [15:0] hitCount;
`endif
  int checks = 0;
  int failures = 0;
  int m_vis[N], m_dig[N], m_left[N], m_wait[N], m_pend[N], m_pdig[N];
  int m_rr, m_valid, m_idx, m_digit, m_hc, respawns;
  logic [7:0] m_lfsr;
  bit seen[10];
  always #5 clk = ~clk;
  number_respawn_scheduler #(.NUMBERS(N), .HIDE_FRAMES(HF), .TIMER_W(9), .LFSR_SEED(8'hA5)) dut (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .freeze(freeze),
    .singleHit(singleHit), .numbersToShow(numbersToShow), .showNum(showNum),
    .scoreValid(scoreValid), .scoreIdx(scoreIdx), .scoreDigit(scoreDigit),
    .scoreReady(scoreReady)
`ifdef NUMSCHED_HIT_COUNT_EN
    , .hitCount(hitCount)
`endif
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic mreset();
    for (int i = 0; i < N; i++) begin
      m_vis[i] = 1; m_dig[i] = i % 10; m_left[i] = 0; m_wait[i] = 0; m_pend[i] = 0; m_pdig[i] = 0;
    end
    m_rr = 0; m_valid = 0; m_idx = 0; m_digit = 0; m_hc = 0; m_lfsr = 8'hA5;
  endtask
  task automatic mstep(input logic [N-1:0] h, input logic s, input logic f, input logic r);
    int srv, nd, g;
    int op[N];
    srv = -1;
    for (int i = 0; i < N; i++) if (m_wait[i] != 0 && srv < 0) srv = i;
    nd = int'(m_lfsr) % 16;
    if (nd >= 10) nd = nd - 6;
    op = m_pend;
    if (m_valid != 0 && r) begin
      m_pend[m_idx] = 0; m_rr = (m_idx + 1) % N; m_valid = 0;
    end else if (m_valid == 0) begin
      for (int k = 0; k < N; k++) begin
        g = (m_rr + k) % N;
        if (op[g] != 0 && m_valid == 0) begin m_valid = 1; m_idx = g; m_digit = m_pdig[g]; end
      end
    end
    for (int i = 0; i < N; i++) begin
      if (m_vis[i] != 0 && h[i] && !f && op[i] == 0) begin
        m_vis[i] = 0; m_left[i] = HF; m_pdig[i] = m_dig[i]; m_pend[i] = 1;
        if (m_hc < 65535) m_hc++;
      end else if (m_vis[i] == 0 && m_wait[i] == 0 && s && !f) begin
        m_left[i]--;
        if (m_left[i] == 0) m_wait[i] = 1;
      end
    end
    if (srv >= 0) begin
      m_dig[srv] = nd; m_vis[srv] = 1; m_wait[srv] = 0; seen[nd] = 1'b1; respawns++;
    end
    m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
  endtask
  task automatic compare();
    logic [N*4-1:0] en;
    logic [N-1:0] es;
    for (int i = 0; i < N; i++) begin
      en[4*i +: 4] = 4'(m_dig[i]);
      es[i] = m_vis[i] != 0;
    end
    check("showNum", 32'(showNum), 32'(es));
    check("numbersToShow", 32'(numbersToShow), 32'(en));
    check("scoreValid", 32'(scoreValid), m_valid);
    check("scoreIdx", 32'(scoreIdx), m_idx);
    check("scoreDigit", 32'(scoreDigit), m_digit);
`ifdef NUMSCHED_HIT_COUNT_EN
    check("hitCount", 32'(hitCount), m_hc);
`endif
  endtask
  task automatic cyc(input logic [N-1:0] h, input logic s, input logic f, input logic r, input logic rs);
    @(negedge clk);
    compare();
    singleHit = h; startOfFrame = s; freeze = f; scoreReady = r; reset = rs;
    if (rs) mreset();
    else mstep(h, s, f, r);
  endtask
  task automatic idle(input int n, input logic s, input logic f, input logic r);
    for (int c = 0; c < n; c++) cyc('0, s && (c % 2 == 0), f, r, 1'b0);
  endtask
  initial begin
    respawns = 0;
    mreset();
    cyc('0, 0, 0, 0, 1);
    cyc('0, 0, 0, 0, 1);
    cyc(3'b010, 0, 0, 1, 0);
    idle(8, 1, 0, 1);
    cyc(3'b111, 0, 0, 0, 0);
    idle(5, 0, 0, 0);
    idle(12, 1, 0, 1);
    cyc(3'b001, 0, 0, 1, 0);
    idle(2, 1, 0, 1);
    idle(20, 1, 1, 1);
    cyc(3'b100, 1, 1, 1, 0);
    idle(12, 1, 0, 1);
    cyc(3'b001, 0, 0, 0, 0);
    idle(10, 1, 0, 0);
    cyc(3'b001, 0, 0, 0, 0);
    idle(3, 0, 0, 1);
    cyc(3'b001, 0, 0, 1, 0);
    idle(12, 1, 0, 1);
    for (int c = 0; c < 30000; c++) begin
      if (c == 15000) begin
        cyc('0, 0, 0, 0, 1);
        cyc('0, 0, 0, 0, 1);
      end
      cyc(N'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0,
          $urandom_range(0, 3) != 0, 1'b0);
    end
    @(negedge clk);
    compare();
    for (int d = 0; d < 10; d++) check($sformatf("digit_seen_%0d", d), 32'(seen[d]), 1);
    check("respawns_enough", 32'(respawns >= 2000), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
